challenge_extract: RTL and testbench
====================================

Name: challenge_extract

Overview:
- Downstream consumer of the SHA3 hash stage. Turns the 512-bit digest into the Picnic Fiat-Shamir challenge vector of NUM_ROUNDS trits.
- Scans the digest two bits at a time: 00→0, 01→1, 10→2, 11→discarded.
- When a digest is exhausted before NUM_ROUNDS trits are collected, it requests a rehash from the hash stage and continues on the new digest.
- Result goes to the response-selection logic of the prover/verifier.

Parameters:
- HASH_W, 512, digest width in bits; must be even.
- NUM_ROUNDS, 219, number of challenge trits to produce.
- CNT_W, 8, width of trit counter and pair index; must hold max(NUM_ROUNDS, HASH_W/2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begin a new extraction, accepted only in IDLE or DONE.
- hash_in  in  HASH_W  digest from hash stage.
- hash_valid  in  1  pulse; hash_in valid this cycle.
- rehash_req  out  1  one-cycle pulse; asks hash stage to hash the previous digest again.
- busy  out  1  high in WAIT_HASH, SCAN, REHASH.
- done  out  1  level; challenge complete.
- ch_out  out  2*NUM_ROUNDS  packed trits; trit i at ch_out[2*i+1:2*i].
- ch_valid  out  1  streaming trit strobe (optional feature).
- ch_trit  out  2  streaming trit value (optional feature).

Behaviour:
- Reset values: all outputs 0, ch_out all 0, state IDLE, counters 0.
- States: IDLE, WAIT_HASH, SCAN, REHASH, DONE.
- IDLE/DONE + start: clear trit_cnt and ch_out, clear done, go to WAIT_HASH.
- start in any other state is ignored.
- WAIT_HASH + hash_valid: latch hash_in into hash_reg, set pair_idx=0, go to SCAN.
- hash_valid in any other state is ignored.
- SCAN examines one pair per cycle, MSB first: pair k = hash_reg[HASH_W-1-2k -: 2].
  - If pair != 11: write it to trit slot trit_cnt, then increment trit_cnt.
  - If the write makes trit_cnt == NUM_ROUNDS: go to DONE next cycle, regardless of pair_idx.
  - Else if pair_idx == HASH_W/2-1: go to REHASH.
  - Else: pair_idx increments.
- REHASH: rehash_req=1 for exactly this one cycle, then WAIT_HASH. trit_cnt is preserved.
- DONE: done=1 held until the next accepted start. ch_out is stable.
- Latency per digest is 1 cycle to latch plus at most HASH_W/2 SCAN cycles.
- Fully valid digest: done rises NUM_ROUNDS+1 cycles after hash_valid.
- Digest of all 11 pairs: rehash_req asserts HASH_W/2+1 cycles after hash_valid. Rehash is unbounded; no timeout.
- Asynchronous reset mid-operation returns to IDLE with all state cleared. A pending rehash is abandoned.

Optional Feature:
- Macro CH_STREAM_EN.
- Defined: each SCAN cycle that writes a trit also drives ch_valid=1 and ch_trit=trit, registered, one cycle after the pair is examined. Exactly NUM_ROUNDS strobes per extraction.
- Undefined: ch_valid and ch_trit tied to 0, no stream logic. ch_out behaviour is identical in both builds.

Decomposition:
- Shared package picnic_ch_pkg holds:
  - state encoding (IDLE..DONE);
  - trit codes TRIT_0=2'b00, TRIT_1=2'b01, TRIT_2=2'b10, PAIR_SKIP=2'b11;
  - default NUM_ROUNDS and HASH_W.
- One natural sub-module: ch_pair_decode, combinational. Inputs: 2-bit pair. Outputs: keep flag and trit value. Instantiated once in the SCAN datapath.

Test Plan:
- Digest all 0x00 → 219 trits of 0; done 220 cycles after hash_valid; rehash_req never asserted.
- Digest first byte 0xE4, rest 0x55 → trits 2,1,0 then 216 trits of 1; done asserted; no rehash.
- Digest all 0xFF → rehash_req pulse exactly once, 257 cycles after hash_valid. Then supply 0xAA.. → all 219 trits = 2, done asserted.
- Boundary: first digest with 218 keep pairs followed by 38 × 11 → rehash, trit_cnt=218. Second digest 0x40.. → trit 218 = 1, done next cycle.
- start and hash_valid pulsed during SCAN → ignored; ch_out and cycle count unchanged from the clean run.
- reset asserted mid-SCAN → busy=0, done=0, ch_out=0 immediately. A new start runs to correct completion.

Source files
------------

// File: rtl/picnic_ch_pkg.sv
// Shared definitions for the Picnic challenge extractor: FSM states, trit codes and
// default sizing.
package picnic_ch_pkg;

    localparam int unsigned HASH_W_DEF     = 512;
    localparam int unsigned NUM_ROUNDS_DEF = 219;
    localparam int unsigned CNT_W_DEF      = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWaitHash,
        StScan,
        StRehash,
        StDone
    } ch_state_e;

    localparam logic [1:0] TRIT_0    = 2'b00;
    localparam logic [1:0] TRIT_1    = 2'b01;
    localparam logic [1:0] TRIT_2    = 2'b10;
    localparam logic [1:0] PAIR_SKIP = 2'b11;

endpackage

// File: rtl/ch_pair_decode.sv
// Maps one digest bit pair to a challenge trit; the pair 11 is rejected.
module ch_pair_decode
    import picnic_ch_pkg::*;
(
    input  logic [1:0] pair_i,
    output logic       keep_o,
    output logic [1:0] trit_o
);

    always_comb begin
        keep_o = 1'b1;
        trit_o = TRIT_0;
        unique case (pair_i)
            TRIT_0:    trit_o = TRIT_0;
            TRIT_1:    trit_o = TRIT_1;
            TRIT_2:    trit_o = TRIT_2;
            PAIR_SKIP: keep_o = 1'b0;
            default:   keep_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/challenge_extract.sv
// Picnic Fiat-Shamir challenge extractor: scans digest pairs MSB first into trits,
// requesting rehashes until NUM_ROUNDS trits are collected. CH_STREAM_EN adds a trit stream.
module challenge_extract
    import picnic_ch_pkg::*;
#(
    parameter int unsigned HASH_W     = HASH_W_DEF,
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [HASH_W-1:0]       hash_in_i,
    input  logic                    hash_valid_i,
    output logic                    rehash_req_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [2*NUM_ROUNDS-1:0] ch_out_o,
    output logic                    ch_valid_o,
    output logic [1:0]              ch_trit_o
);

    ch_state_e               state_q, state_d;
    logic [HASH_W-1:0]       hash_q, hash_d;
    logic [CNT_W-1:0]        trit_cnt_q, trit_cnt_d;
    logic [CNT_W-1:0]        pair_idx_q, pair_idx_d;
    logic [2*NUM_ROUNDS-1:0] ch_out_q, ch_out_d;

    logic       keep;
    logic [1:0] trit;
    logic       scan_write;

    // The digest register shifts left each SCAN cycle, so the current pair is always on top.
    ch_pair_decode u_pair_decode (
        .pair_i (hash_q[HASH_W-1 -: 2]),
        .keep_o (keep),
        .trit_o (trit)
    );

    assign scan_write = (state_q == StScan) && keep;

    always_comb begin
        state_d    = state_q;
        hash_d     = hash_q;
        trit_cnt_d = trit_cnt_q;
        pair_idx_d = pair_idx_q;
        ch_out_d   = ch_out_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    trit_cnt_d = '0;
                    ch_out_d   = '0;
                    state_d    = StWaitHash;
                end
            end
            StWaitHash: begin
                if (hash_valid_i) begin
                    hash_d     = hash_in_i;
                    pair_idx_d = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                hash_d = hash_q << 2;
                if (keep) begin
                    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
                        if (trit_cnt_q == CNT_W'(i)) begin
                            ch_out_d[2*i +: 2] = trit;
                        end
                    end
                    trit_cnt_d = trit_cnt_q + CNT_W'(1);
                end
                if (keep && (trit_cnt_q == CNT_W'(NUM_ROUNDS - 1))) begin
                    state_d = StDone;
                end else if (pair_idx_q == CNT_W'(HASH_W / 2 - 1)) begin
                    state_d = StRehash;
                end else begin
                    pair_idx_d = pair_idx_q + CNT_W'(1);
                end
            end
            StRehash: state_d = StWaitHash;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hash_q     <= '0;
            trit_cnt_q <= '0;
            pair_idx_q <= '0;
            ch_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            hash_q     <= hash_d;
            trit_cnt_q <= trit_cnt_d;
            pair_idx_q <= pair_idx_d;
            ch_out_q   <= ch_out_d;
        end
    end

    assign rehash_req_o = (state_q == StRehash);
    assign busy_o       = (state_q == StWaitHash) || (state_q == StScan) || (state_q == StRehash);
    assign done_o       = (state_q == StDone);
    assign ch_out_o     = ch_out_q;

`ifdef CH_STREAM_EN
    logic       ch_valid_q;
    logic [1:0] ch_trit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_valid_q <= 1'b0;
            ch_trit_q  <= 2'b00;
        end else begin
            ch_valid_q <= scan_write;
            ch_trit_q  <= scan_write ? trit : 2'b00;
        end
    end

    assign ch_valid_o = ch_valid_q;
    assign ch_trit_o  = ch_trit_q;
`else
    logic unused_scan_write;
    assign unused_scan_write = scan_write;
    assign ch_valid_o        = 1'b0;
    assign ch_trit_o         = 2'b00;
`endif

endmodule

// File: tb/tb_challenge_extract.sv
// Directed bench for challenge_extract: table of whole-digest vectors plus hand-written
// rehash, boundary, ignored-input and mid-scan reset sequences.
module tb_challenge_extract;

    localparam int HW = 512;
    localparam int NR = 219;
    localparam int CW = 2 * NR;

`ifdef CH_STREAM_EN
    localparam int EXP_STROBES = NR;
`else
    localparam int EXP_STROBES = 0;
`endif

    logic          clk;
    logic          reset;
    logic          start_i;
    logic [HW-1:0] hash_in_i;
    logic          hash_valid_i;
    logic          rehash_req_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] ch_out_o;
    logic          ch_valid_o;
    logic [1:0]    ch_trit_o;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;

    challenge_extract dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .hash_in_i    (hash_in_i),
        .hash_valid_i (hash_valid_i),
        .rehash_req_o (rehash_req_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ch_out_o     (ch_out_o),
        .ch_valid_o   (ch_valid_o),
        .ch_trit_o    (ch_trit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ch_valid_o === 1'b1) strobe_cnt++;

    typedef struct {
        string         name;
        logic [HW-1:0] digest;
        logic [CW-1:0] exp_ch;
        int            exp_cyc;
    } vec_t;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        strobe_cnt = 0;
    endtask

    // Pulses hash_valid with d, then counts cycles until done or rehash_req (hash_valid cycle = 0).
    // At cycle inject_at a stray start/hash_valid pair is driven.
    task automatic feed(input logic [HW-1:0] d, input int inject_at, output int cyc,
                        output bit got_done, output bit got_rehash);
        hash_in_i    = d;
        hash_valid_i = 1'b1;
        @(posedge clk);
        #1 hash_valid_i = 1'b0;
        cyc = 1;
        while (!done_o && !rehash_req_o && cyc < 1000) begin
            if (cyc == inject_at) begin
                start_i      = 1'b1;
                hash_valid_i = 1'b1;
                hash_in_i    = '1;
            end
            @(posedge clk);
            #1 start_i = 1'b0;
            hash_valid_i = 1'b0;
            cyc++;
        end
        got_done   = done_o;
        got_rehash = rehash_req_o;
        if (cyc >= 1000) begin
            errors++;
            checks++;
            $display("FAIL timeout: no done or rehash_req within 1000 cycles");
        end
    endtask

    task automatic run_clean(input vec_t v, input int inject_at);
        int            cyc;
        bit            gd;
        bit            gr;
        logic [CW-1:0] snap;
        do_start();
        feed(v.digest, inject_at, cyc, gd, gr);
        check({v.name, " done cycle"}, CW'(cyc), CW'(v.exp_cyc));
        check({v.name, " no rehash"}, CW'(gr), CW'(0));
        check({v.name, " ch_out"}, ch_out_o, v.exp_ch);
        snap = ch_out_o;
        repeat (3) @(posedge clk);
        #1;
        check({v.name, " done held"}, CW'(done_o), CW'(1));
        check({v.name, " ch_out stable"}, ch_out_o, snap);
        check({v.name, " busy low in done"}, CW'(busy_o), CW'(0));
        check({v.name, " stream strobes"}, CW'(strobe_cnt), CW'(EXP_STROBES));
    endtask

    initial begin
        vec_t          vecs[3];
        int            cyc;
        bit            gd;
        bit            gr;
        logic [CW-1:0] b218;

        vecs[0] = '{"zeros", {HW{1'b0}}, {CW{1'b0}}, 220};
        vecs[1] = '{"e4_55", {8'hE4, {63{8'h55}}}, {{216{2'b01}}, 2'b00, 2'b01, 2'b10}, 221};
        vecs[2] = '{"aa", {64{8'hAA}}, {NR{2'b10}}, 220};

        reset        = 1'b0;
        start_i      = 1'b0;
        hash_in_i    = '0;
        hash_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", CW'(busy_o), CW'(0));
        check("reset done", CW'(done_o), CW'(0));
        check("reset rehash", CW'(rehash_req_o), CW'(0));
        check("reset ch_out", ch_out_o, '0);
        check("reset ch_valid", CW'({ch_valid_o, ch_trit_o}), CW'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) run_clean(vecs[i], -1);

        // Restart from DONE clears the result immediately.
        do_start();
        check("restart done cleared", CW'(done_o), CW'(0));
        check("restart ch_out cleared", ch_out_o, '0);
        check("restart busy", CW'(busy_o), CW'(1));

        // All-11 digest: one rehash pulse, then a valid digest completes.
        feed({HW{1'b1}}, -1, cyc, gd, gr);
        check("ff rehash cycle", CW'(cyc), CW'(257));
        check("ff rehash seen", CW'(gr), CW'(1));
        check("ff busy in rehash", CW'(busy_o), CW'(1));
        @(posedge clk);
        #1;
        check("ff rehash single pulse", CW'(rehash_req_o), CW'(0));
        feed({64{8'hAA}}, -1, cyc, gd, gr);
        check("ff->aa done cycle", CW'(cyc), CW'(220));
        check("ff->aa ch_out", ch_out_o, {NR{2'b10}});

        // 218 trits then 38 skipped pairs, then one more trit from the next digest.
        do_start();
        feed({{218{2'b10}}, {38{2'b11}}}, -1, cyc, gd, gr);
        check("bnd rehash cycle", CW'(cyc), CW'(257));
        check("bnd rehash seen", CW'(gr), CW'(1));
        b218 = {2'b00, {218{2'b10}}};
        check("bnd partial ch_out", ch_out_o, b218);
        @(posedge clk);
        #1;
        feed({8'h40, {63{8'h00}}}, -1, cyc, gd, gr);
        check("bnd done cycle", CW'(cyc), CW'(2));
        check("bnd done", CW'(gd), CW'(1));
        b218 = {2'b01, {218{2'b10}}};
        check("bnd final ch_out", ch_out_o, b218);

        // Stray start/hash_valid during SCAN must not disturb a run.
        run_clean(vecs[1], 50);

        // Asynchronous reset mid-SCAN.
        do_start();
        hash_in_i    = {64{8'hAA}};
        hash_valid_i = 1'b1;
        @(posedge clk);
        #1 hash_valid_i = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid-scan ch_out nonzero", CW'(ch_out_o != '0), CW'(1));
        #2 reset = 1'b0;
        #1;
        check("async reset busy", CW'(busy_o), CW'(0));
        check("async reset done", CW'(done_o), CW'(0));
        check("async reset ch_out", ch_out_o, '0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post reset idle", CW'(busy_o), CW'(0));
        run_clean(vecs[1], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
